pio_multi: RTL and testbench

- Parametrised successor to the single-register parallel output port.
- Holds a packed output word {gpio, led, counter_set} behind a small 4-register bus window, with byte-enable writes, registered readback, synchronised GPIO input and per-LED hardware blink.
- Sits on the CPU data bus beside the memory-mapped peripherals.
- Drives board LEDs, the counter-select lines and general GPIO outputs.

---
 rtl/pio_multi_pkg.sv | 24 ++
 rtl/pio_blink_gen.sv | 41 ++++
 rtl/pio_multi.sv | 122 ++++++++++++
 tb/tb_pio_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_multi_pkg.sv
// Shared constants and byte-enable merge helper for the multi-register parallel I/O port.
// Blink hardware is built only when PIO_MULTI_BLINK_EN is defined.
package pio_multi_pkg;

    localparam logic [1:0] ADDR_OUT   = 2'd0;
    localparam logic [1:0] ADDR_BLINK = 2'd1;
    localparam logic [1:0] ADDR_IN    = 2'd2;

    localparam int RATE_LSB = 16;
    localparam int RATE_W   = 5;

    // Byte k of the result comes from wdat where be[k]=1, otherwise from cur.
    function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) res[8*k +: 8] = wdat[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pio_blink_gen.sv
// Free-running blink prescaler; phase inverts each time the low (s+1) prescaler bits are all ones.
// restart clears the prescaler and forces phase on, overriding a same-edge toggle.
module pio_blink_gen
    import pio_multi_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic [RATE_W-1:0] rate,
    output logic              phase
);

    logic [DIV_W-1:0]  prescaler;
    logic [DIV_W-1:0]  low_mask;
    logic [RATE_W-1:0] sel;
    logic              toggle;

    always_comb begin
        sel = rate;
        if (int'(rate) > DIV_W - 1) sel = RATE_W'(DIV_W - 1);
        low_mask = {DIV_W{1'b1}} >> (DIV_W - 1 - int'(sel));
    end

    assign toggle = &(prescaler | ~low_mask);

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
            phase     <= 1'b1;
        end else if (restart) begin
            prescaler <= '0;
            phase     <= 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (toggle) phase <= ~phase;
        end
    end

endmodule

// File: rtl/pio_multi.sv
// Parallel output port: packed {gpio, led, counter_set} word, blink control, synchronised GPIO input.
// Optional hardware blink is enabled by defining PIO_MULTI_BLINK_EN.
module pio_multi
    import pio_multi_pkg::*;
#(
    parameter int               LED_W   = 8,
    parameter int               CSET_W  = 2,
    parameter int               GPIO_W  = 22,
    parameter logic [LED_W-1:0] LED_RST = LED_W'(8'h2A),
    parameter int               DIV_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [3:0]        be,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [CSET_W-1:0] counter_set,
    output logic [LED_W-1:0]  led_out,
    output logic [GPIO_W-1:0] gpio_out
);

    if (LED_W + CSET_W + GPIO_W != 32) begin : g_bad_width
        $error("pio_multi: LED_W+CSET_W+GPIO_W must equal 32");
    end

    // Bus protocol: en qualifies a transfer on the falling edge; we=1 writes the
    // byte-enabled lanes, we=0 loads data_out one edge later; idle or write holds data_out.
    logic              wr;
    logic              rd;
    logic [31:0]       out_q;
    logic [31:0]       blink_word;
    logic [31:0]       rd_word;
    logic [GPIO_W-1:0] sync1_q;
    logic [GPIO_W-1:0] sync2_q;
    logic [LED_W-1:0]  led;

    assign wr = en & we;
    assign rd = en & ~we;

    assign counter_set = out_q[CSET_W-1:0];
    assign led         = out_q[CSET_W +: LED_W];
    assign gpio_out    = out_q[CSET_W+LED_W +: GPIO_W];

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= {{GPIO_W{1'b0}}, LED_RST, {CSET_W{1'b0}}};
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            if (wr && addr == ADDR_OUT) out_q <= be_merge(out_q, data_in, be);
        end
    end

`ifdef PIO_MULTI_BLINK_EN
    logic [LED_W-1:0]  blink_mask;
    logic [LED_W-1:0]  mask_nxt;
    logic [RATE_W-1:0] rate;
    logic [RATE_W-1:0] rate_nxt;
    logic              restart;
    logic              phase;

    assign blink_word = 32'(blink_mask) | (32'(rate) << RATE_LSB);

    always_comb begin
        mask_nxt = blink_mask;
        for (int i = 0; i < LED_W; i++) begin
            if (be[i/8]) mask_nxt[i] = data_in[i];
        end
        rate_nxt = be[RATE_LSB/8] ? data_in[RATE_LSB +: RATE_W] : rate;
    end

    // Writing the rate byte restarts the blink cycle from the on phase.
    assign restart = wr && (addr == ADDR_BLINK) && be[RATE_LSB/8];

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            blink_mask <= '0;
            rate       <= '0;
        end else if (wr && addr == ADDR_BLINK) begin
            blink_mask <= mask_nxt;
            rate       <= rate_nxt;
        end
    end

    pio_blink_gen #(
        .DIV_W(DIV_W)
    ) u_blink (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .rate   (rate),
        .phase  (phase)
    );

    assign led_out = led & (~blink_mask | {LED_W{phase}});
`else
    assign blink_word = '0;
    assign led_out    = led;
`endif

    always_comb begin
        rd_word = '0;
        case (addr)
            ADDR_OUT:   rd_word = out_q;
            ADDR_BLINK: rd_word = blink_word;
            ADDR_IN:    rd_word = 32'(sync2_q);
            default:    rd_word = '0;
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst)    data_out <= '0;
        else if (rd) data_out <= rd_word;
    end

endmodule

// File: tb/tb_pio_multi.sv
// Bench for pio_multi: fixed vectors, hand sequences for blink/sync/reset, random traffic vs a model.
// Blink expectations follow PIO_MULTI_BLINK_EN.
module tb_pio_multi;

    logic        clk;
    logic        rst;
    logic        en;
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [21:0] gpio_in;
    logic [1:0]  counter_set;
    logic [7:0]  led_out;
    logic [21:0] gpio_out;

    int checks = 0;
    int fails  = 0;

    pio_multi dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .we         (we),
        .addr       (addr),
        .be         (be),
        .data_in    (data_in),
        .data_out   (data_out),
        .gpio_in    (gpio_in),
        .counter_set(counter_set),
        .led_out    (led_out),
        .gpio_out   (gpio_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PIO_MULTI_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    // reference model state
    logic [31:0] m_out;
    logic [7:0]  m_mask;
    logic [4:0]  m_rate;
    logic [31:0] m_dout;
    logic [21:0] gin_q[$];
    longint      m_n;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out  = {22'h0, 8'h2A, 2'b00};
        m_mask = '0;
        m_rate = '0;
        m_dout = '0;
        gin_q  = {22'h0, 22'h0};
        m_n    = 0;
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] cur, input logic [31:0] d,
                                               input logic [3:0] b);
        logic [31:0] r;
        r = cur;
        if (b[0]) r[7:0]   = d[7:0];
        if (b[1]) r[15:8]  = d[15:8];
        if (b[2]) r[23:16] = d[23:16];
        if (b[3]) r[31:24] = d[31:24];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_out;
            2'd1:    return BLINK_ON ? {11'h0, m_rate, 8'h0, m_mask} : 32'h0;
            2'd2:    return {10'h0, gin_q[0]};
            default: return 32'h0;
        endcase
    endfunction

    // Phase is on for the first half of each 2^(s+2)-edge period since the last restart.
    function automatic logic [7:0] m_led();
        logic [7:0] l;
        int         s;
        longint     half;
        l = m_out[9:2];
        if (BLINK_ON) begin
            s    = (m_rate > 5'd23) ? 23 : int'(m_rate);
            half = longint'(1) << (s + 1);
            if (((m_n / half) % 2) != 0) l = l & ~m_mask;
        end
        return l;
    endfunction

    task automatic model_edge(input logic e, input logic w, input logic [1:0] a,
                              input logic [3:0] b, input logic [31:0] d, input logic [21:0] g);
        logic [31:0] bw;
        if (e && !w) m_dout = m_read(a);
        gin_q.push_back(g);
        void'(gin_q.pop_front());
        m_n++;
        if (e && w && a == 2'd0) m_out = lane_merge(m_out, d, b);
        if (BLINK_ON && e && w && a == 2'd1) begin
            bw     = lane_merge({11'h0, m_rate, 8'h0, m_mask}, d, b);
            m_mask = bw[7:0];
            m_rate = bw[20:16];
            if (b[2]) m_n = 0;
        end
    endtask

    task automatic model_check(input string tag);
        check({tag, ".led_out"},     32'(led_out),     32'(m_led()));
        check({tag, ".counter_set"}, 32'(counter_set), 32'(m_out[1:0]));
        check({tag, ".gpio_out"},    32'(gpio_out),    32'(m_out[31:10]));
        check({tag, ".data_out"},    data_out,         m_dout);
    endtask

    // driver: inputs change at posedge+1, DUT updates on negedge, outputs sampled at next posedge+1
    task automatic tick(input logic e, input logic w, input logic [1:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [21:0] g, input string tag);
        en = e; we = w; addr = a; be = b; data_in = d; gpio_in = g;
        @(negedge clk);
        model_edge(e, w, a, b, d, g);
        @(posedge clk);
        #1;
        model_check(tag);
    endtask

    typedef struct {
        logic        en;
        logic        we;
        logic [1:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [7:0]  led;
        logic [1:0]  cset;
        logic [21:0] gpio;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[11];

    logic [7:0]  blink0_exp[7];
    logic        r_e, r_w;
    logic [1:0]  r_a;
    logic [3:0]  r_b;
    logic [31:0] r_d;
    logic [21:0] r_g;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 2'd1, 4'h0, 32'h0,        8'h2A, 2'd0, 22'h0,      32'h0};
        vecs[1]  = '{1'b1, 1'b1, 2'd0, 4'hF, 32'hDEADBEEF, 8'hBB, 2'd3, 22'h37AB6F, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 4'h0, 32'h0,        8'hBB, 2'd3, 22'h37AB6F, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b1, 2'd0, 4'h1, 32'h00000055, 8'h95, 2'd1, 22'h37AB6F, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 4'h0, 32'h0,        8'h95, 2'd1, 22'h37AB6F, 32'hDEADBE55};
        vecs[5]  = '{1'b1, 1'b1, 2'd0, 4'h0, 32'h0,        8'h95, 2'd1, 22'h37AB6F, 32'hDEADBE55};
        vecs[6]  = '{1'b0, 1'b1, 2'd0, 4'hF, 32'h0,        8'h95, 2'd1, 22'h37AB6F, 32'hDEADBE55};
        vecs[7]  = '{1'b1, 1'b1, 2'd3, 4'hF, 32'hFFFFFFFF, 8'h95, 2'd1, 22'h37AB6F, 32'hDEADBE55};
        vecs[8]  = '{1'b1, 1'b0, 2'd3, 4'h0, 32'h0,        8'h95, 2'd1, 22'h37AB6F, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 2'd0, 4'hA, 32'h12345678, 8'h95, 2'd1, 22'h04AB55,  32'h0};
        vecs[10] = '{1'b1, 1'b0, 2'd0, 4'h0, 32'h0,        8'h95, 2'd1, 22'h04AB55,  32'h12AD5655};

        blink0_exp = '{8'hFF, 8'hFF, 8'h0F, 8'h0F, 8'hFF, 8'hFF, 8'h0F};

        rst = 1'b0; en = 1'b0; we = 1'b0; addr = '0; be = '0; data_in = '0; gpio_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.led_out",     32'(led_out),     32'h2A);
        check("reset.counter_set", 32'(counter_set), 32'h0);
        check("reset.gpio_out",    32'(gpio_out),    32'h0);
        check("reset.data_out",    data_out,         32'h0);
        model_reset();
        rst = 1'b1;

        // fixed vectors
        for (int i = 0; i < 11; i++) begin
            tick(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].data, 22'h0, "vec");
            check($sformatf("vec%0d.led_out", i),     32'(led_out),     32'(vecs[i].led));
            check($sformatf("vec%0d.counter_set", i), 32'(counter_set), 32'(vecs[i].cset));
            check($sformatf("vec%0d.gpio_out", i),    32'(gpio_out),    32'(vecs[i].gpio));
            check($sformatf("vec%0d.data_out", i),    data_out,         vecs[i].dout);
        end

        // GPIO synchroniser latency while reading IN every edge
        tick(1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 22'h0, "sync");
        tick(1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 22'h0, "sync");
        for (int k = 1; k <= 5; k++) begin
            tick(1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 22'h3FFFFF, "sync");
            check($sformatf("sync_edge%0d", k), data_out, (k >= 3) ? 32'h003FFFFF : 32'h0);
        end

        // blink at rate 0, then rate 3
        tick(1'b1, 1'b1, 2'd0, 4'hF, 32'h000003FC, 22'h0, "led_ff");
        tick(1'b1, 1'b1, 2'd1, 4'hF, 32'h000000F0, 22'h0, "blink0");
        check("blink0_n0", 32'(led_out), BLINK_ON ? 32'(blink0_exp[0]) : 32'hFF);
        for (int n = 1; n < 7; n++) begin
            tick(1'b1, 1'b0, 2'd1, 4'h0, 32'h0, 22'h0, "blink0");
            check($sformatf("blink0_n%0d", n), 32'(led_out),
                  BLINK_ON ? 32'(blink0_exp[n]) : 32'hFF);
        end
        check("blink0_rd", data_out, BLINK_ON ? 32'h000000F0 : 32'h0);
        tick(1'b1, 1'b1, 2'd1, 4'hF, 32'h000300F0, 22'h0, "blink3");
        for (int n = 1; n <= 40; n++) begin
            tick(1'b1, 1'b0, 2'd1, 4'h0, 32'h0, 22'h0, "blink3");
            if (n == 15 || n == 16 || n == 31 || n == 32)
                check($sformatf("blink3_n%0d", n), 32'(led_out),
                      (BLINK_ON && (n == 16 || n == 31)) ? 32'h0F : 32'hFF);
        end
        check("blink3_rd", data_out, BLINK_ON ? 32'h000300F0 : 32'h0);

        // asynchronous reset mid-blink, then first toggle at the reset rate
        rst = 1'b0;
        #1;
        check("midrst.led_out",     32'(led_out),     32'h2A);
        check("midrst.counter_set", 32'(counter_set), 32'h0);
        check("midrst.data_out",    data_out,         32'h0);
        model_reset();
        #1;
        rst = 1'b1;
        tick(1'b1, 1'b1, 2'd1, 4'h1, 32'h000000FF, 22'h0, "postrst");
        check("postrst_n1", 32'(led_out), 32'h2A);
        tick(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 22'h0, "postrst");
        check("postrst_n2", 32'(led_out), BLINK_ON ? 32'h00 : 32'h2A);
        tick(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 22'h0, "postrst");
        tick(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 22'h0, "postrst");
        check("postrst_n4", 32'(led_out), 32'h2A);

        // random traffic against the model
        r_g = '0;
        for (int i = 0; i < 400; i++) begin
            r_e = ($urandom_range(0, 9) < 8);
            r_w = 1'($urandom_range(0, 1));
            r_a = 2'($urandom_range(0, 3));
            r_b = 4'($urandom_range(0, 15));
            r_d = $urandom;
            if (r_a == 2'd1) r_d[20:16] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) r_g = 22'($urandom);
            tick(r_e, r_w, r_a, r_b, r_d, r_g, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
